// File: rtl/adv_pkg.sv
// Shared types and constants for the scripted adventure player.
// Room indices follow the game's one-hot status bit order {d, win, s6..s0}.
package adv_pkg;

  typedef logic [3:0] dir_t;

  localparam dir_t DIR_NONE = 4'b0000;
  localparam dir_t DIR_N    = 4'b1000;
  localparam dir_t DIR_S    = 4'b0100;
  localparam dir_t DIR_E    = 4'b0010;
  localparam dir_t DIR_W    = 4'b0001;

  localparam logic [3:0] S0   = 4'd0;
  localparam logic [3:0] S1   = 4'd1;
  localparam logic [3:0] S2   = 4'd2;
  localparam logic [3:0] S3   = 4'd3;
  localparam logic [3:0] S4   = 4'd4;
  localparam logic [3:0] S5   = 4'd5;
  localparam logic [3:0] S6   = 4'd6;
  localparam logic [3:0] WIN  = 4'd7;
  localparam logic [3:0] DEAD = 4'd8;

  localparam logic [2:0] WIN_LEN  = 3'd6;
  localparam logic [2:0] LOSE_LEN = 3'd4;

  typedef struct packed {
    dir_t       dir;
    logic [3:0] room;
    logic       sword;
  } route_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHECK,
    ST_DRIVE,
    ST_RELEASE,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic [8:0] roomMask(input logic [3:0] idx);
    return 9'b1 << idx;
  endfunction

  function automatic logic [2:0] routeLen(input logic loseSel);
    return loseSel ? LOSE_LEN : WIN_LEN;
  endfunction

endpackage

// File: rtl/adv_route_rom.sv
// Built-in win and lose routes; step 1 is the first move, other indices read as empty.
module adv_route_rom (
  input  logic       routeSel_i,
  input  logic [2:0] step_i,
  output logic [8:0] entry_o
);

  import adv_pkg::*;

  route_entry_t entry;

  always_comb begin
    entry = '{dir: DIR_NONE, room: S0, sword: 1'b0};
    if (!routeSel_i) begin
      case (step_i)
        3'd1:    entry = '{dir: DIR_E,         room: S1,  sword: 1'b0};
        3'd2:    entry = '{dir: DIR_S,         room: S2,  sword: 1'b0};
        3'd3:    entry = '{dir: DIR_W,         room: S3,  sword: 1'b1};
        3'd4:    entry = '{dir: DIR_E,         room: S2,  sword: 1'b1};
        3'd5:    entry = '{dir: DIR_S | DIR_E, room: S4,  sword: 1'b1};
        3'd6:    entry = '{dir: DIR_N,         room: WIN, sword: 1'b1};
        default: entry = '{dir: DIR_NONE,      room: S0,  sword: 1'b0};
      endcase
    end else begin
      case (step_i)
        3'd1:    entry = '{dir: DIR_E,         room: S1,   sword: 1'b0};
        3'd2:    entry = '{dir: DIR_S,         room: S2,   sword: 1'b0};
        3'd3:    entry = '{dir: DIR_S | DIR_E, room: S4,   sword: 1'b0};
        3'd4:    entry = '{dir: DIR_N,         room: DEAD, sword: 1'b0};
        default: entry = '{dir: DIR_NONE,      room: S0,   sword: 1'b0};
      endcase
    end
  end

  assign entry_o = entry;

endmodule

// File: rtl/adventure_player.sv
// Scripted player replaying a win or lose route against the adventure game.
// Define ADV_PLAYER_SWORD_CHECK_EN to also compare the sword flag at each check.
module adventure_player #(
  parameter int HOLD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       route_sel,
  input  logic [8:0] room_i,
  input  logic       sword_i,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [2:0] step
);

  import adv_pkg::*;

  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic        routeSel_q, routeSel_d;
  logic [3:0]  expRoom_q, expRoom_d;
  logic        expSword_q, expSword_d;
  dir_t        dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;

  logic         checkOk;
  logic         roomOk;
  logic         swordOk;
  logic [8:0]   romBits;
  route_entry_t romEntry;

  // The ROM is addressed with the upcoming step so the direction register
  // is loaded on the same edge that enters DRIVE.
  adv_route_rom routeRom (
    .routeSel_i (routeSel_d),
    .step_i     (step_d),
    .entry_o    (romBits)
  );

  assign romEntry = route_entry_t'(romBits);
  assign roomOk   = (room_i == roomMask(expRoom_q));

`ifdef ADV_PLAYER_SWORD_CHECK_EN
  assign swordOk = (sword_i == expSword_q);
`else
  logic unusedSword;
  assign unusedSword = sword_i ^ expSword_q;
  assign swordOk     = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      step_q     <= 3'd0;
      cnt_q      <= 16'd0;
      routeSel_q <= 1'b0;
      expRoom_q  <= S0;
      expSword_q <= 1'b0;
      dir_q      <= DIR_NONE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      routeSel_q <= routeSel_d;
      expRoom_q  <= expRoom_d;
      expSword_q <= expSword_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    routeSel_d = routeSel_q;
    checkOk    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_PRECHECK;
          routeSel_d = route_sel;
          step_d     = 3'd0;
        end
      end
      ST_PRECHECK: begin
        checkOk = (room_i == roomMask(S0));
        if (checkOk) begin
          state_d = ST_DRIVE;
          step_d  = 3'd1;
          cnt_d   = 16'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_CHECK: begin
        checkOk = roomOk && swordOk;
        if (!checkOk || (step_q == routeLen(routeSel_q))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          step_d  = step_q + 3'd1;
          cnt_d   = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Verdict flags are captured on the edge entering DONE and held there.
  always_comb begin
    busy_d     = state_d inside {ST_PRECHECK, ST_DRIVE, ST_RELEASE, ST_CHECK};
    done_d     = (state_d == ST_DONE);
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    dir_d      = DIR_NONE;
    expRoom_d  = expRoom_q;
    expSword_d = expSword_q;
    if (state_d == ST_DONE) begin
      if (state_q == ST_DONE) begin
        pass_d = pass_q;
        fail_d = fail_q;
      end else begin
        pass_d = checkOk;
        fail_d = !checkOk;
      end
    end
    if (state_d == ST_DRIVE) begin
      dir_d      = romEntry.dir;
      expRoom_d  = romEntry.room;
      expSword_d = romEntry.sword;
    end
  end

  assign n    = dir_q[3];
  assign s    = dir_q[2];
  assign e    = dir_q[1];
  assign w    = dir_q[0];
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign fail = fail_q;
  assign step = step_q;

endmodule
